// File: rtl/bram_loader_if.sv
// Load-side bundle for bram_loader: the input word stream, the two BRAM write
// ports, and the status outputs. The loader is the slave; the data source is the master.
interface bram_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    logic                  ena_A;
    logic                  wea_A;
    logic [4:0]            addra_A;
    logic [DATA_WIDTH-1:0] dina_A;

    logic                  ena_B;
    logic                  wea_B;
    logic [4:0]            addra_B;
    logic [DATA_WIDTH-1:0] dina_B;

    logic                  busy;
    logic                  done;
    logic [5:0]            word_count;

    modport master (
        output start, in_valid, in_data,
        input  in_ready,
        input  ena_A, wea_A, addra_A, dina_A,
        input  ena_B, wea_B, addra_B, dina_B,
        input  busy, done, word_count
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready,
        output ena_A, wea_A, addra_A, dina_A,
        output ena_B, wea_B, addra_B, dina_B,
        output busy, done, word_count
    );
endinterface

// File: rtl/bram_loader.sv
// Streams 2*DEPTH words into two BRAMs: the first DEPTH fill BRAM A, the next DEPTH fill
// BRAM B. Write strobes follow each accepted word by exactly one registered cycle.
module bram_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 21
) (
    input logic         clk,
    input logic         rst,
    bram_loader_if.slave bus
);
    localparam int AW = 5;
    localparam int CW = 6;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            loading;
    logic            beat;
    logic            at_last;
    logic            wr_a;
    logic            wr_b;
    logic            last_write;

    logic                  ena_a_q;
    logic                  ena_b_q;
    logic                  done_q;
    logic [AW-1:0]         addr_a_q;
    logic [AW-1:0]         addr_b_q;
    logic [DATA_WIDTH-1:0] din_a_q;
    logic [DATA_WIDTH-1:0] din_b_q;

    // in_ready depends only on state, so a source may legally wait for it before asserting in_valid.
    assign loading    = (state_q != IDLE);
    assign beat       = bus.in_valid & loading;
    assign at_last    = (ptr_q == LAST_ADDR);
    assign wr_a       = beat & (state_q == LOAD_A);
    assign wr_b       = beat & (state_q == LOAD_B);
    assign last_write = wr_b & at_last;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD_A;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            LOAD_A: begin
                if (beat) begin
                    count_d = count_q + 6'd1;
                    if (at_last) begin
                        ptr_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
            end
            LOAD_B: begin
                if (beat) begin
                    count_d = count_q + 6'd1;
                    if (at_last) begin
                        ptr_d   = '0;
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Address and data only load on a strobe, so they keep the last written word between writes.
    // NOTE: reset clears these registers too, since the BRAM-side outputs have defined reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ena_a_q  <= 1'b0;
            ena_b_q  <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            din_a_q  <= '0;
            din_b_q  <= '0;
        end else begin
            ena_a_q <= wr_a;
            ena_b_q <= wr_b;
            done_q  <= last_write;
            if (wr_a) begin
                addr_a_q <= ptr_q;
                din_a_q  <= bus.in_data;
            end
            if (wr_b) begin
                addr_b_q <= ptr_q;
                din_b_q  <= bus.in_data;
            end
        end
    end

    // The block never reads, so write-enable always mirrors port enable.
    assign bus.in_ready   = loading;
    assign bus.busy       = loading;
    assign bus.done       = done_q;
    assign bus.word_count = count_q;

    assign bus.ena_A   = ena_a_q;
    assign bus.wea_A   = ena_a_q;
    assign bus.addra_A = addr_a_q;
    assign bus.dina_A  = din_a_q;

    assign bus.ena_B   = ena_b_q;
    assign bus.wea_B   = ena_b_q;
    assign bus.addra_B = addr_b_q;
    assign bus.dina_B  = din_b_q;

endmodule
